// File: rtl/program_loader.sv
// Streams host words into instruction/data memories over valid/ready, holding the core in reset until done.
// Optional PROGRAM_LOADER_CHECKSUM_EN: the loadLast word is a checksum compared against the payload sum.
module program_loader #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned INSTR_ADDR_WIDTH = 7,
   parameter int unsigned DATA_ADDR_WIDTH  = 7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        loadValid,
   output logic                        loadReady,
   input  logic [DATA_WIDTH-1:0]       loadWord,
   input  logic                        loadTarget,
   input  logic                        loadLast,
   output logic                        imemWe,
   output logic [INSTR_ADDR_WIDTH-1:0] imemAddr,
   output logic [DATA_WIDTH-1:0]       imemData,
   output logic                        dmemWe,
   output logic [DATA_ADDR_WIDTH-1:0]  dmemAddr,
   output logic [DATA_WIDTH-1:0]       dmemData,
   output logic                        coreHold,
   output logic                        done,
   output logic                        overflow,
   output logic                        checksumErr
);

   localparam int unsigned ICNT_W = INSTR_ADDR_WIDTH + 1;
   localparam int unsigned DCNT_W = DATA_ADDR_WIDTH + 1;
   localparam logic [ICNT_W-1:0] IMEM_FULL = ICNT_W'(1) << INSTR_ADDR_WIDTH;
   localparam logic [DCNT_W-1:0] DMEM_FULL = DCNT_W'(1) << DATA_ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                      state_q, state_d;
   logic [ICNT_W-1:0]           icnt_q, icnt_d;
   logic [DCNT_W-1:0]           dcnt_q, dcnt_d;
   logic [DATA_WIDTH-1:0]       accum_q, accum_d;
   logic                        ready_q, ready_d;
   logic                        hold_q, hold_d;
   logic                        done_q, done_d;
   logic                        imem_we_q, imem_we_d;
   logic [INSTR_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0]       imem_data_q, imem_data_d;
   logic                        dmem_we_q, dmem_we_d;
   logic [DATA_ADDR_WIDTH-1:0]  dmem_addr_q, dmem_addr_d;
   logic [DATA_WIDTH-1:0]       dmem_data_q, dmem_data_d;
   logic                        overflow_q, overflow_d;
   logic                        xfer;
   logic                        payload;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic                        cksum_err_q, cksum_err_d;
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         icnt_q      <= '0;
         dcnt_q      <= '0;
         accum_q     <= '0;
         ready_q     <= 1'b0;
         hold_q      <= 1'b1;
         done_q      <= 1'b0;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         dmem_we_q   <= 1'b0;
         dmem_addr_q <= '0;
         dmem_data_q <= '0;
         overflow_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         cksum_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         icnt_q      <= icnt_d;
         dcnt_q      <= dcnt_d;
         accum_q     <= accum_d;
         ready_q     <= ready_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         imem_we_q   <= imem_we_d;
         imem_addr_q <= imem_addr_d;
         imem_data_q <= imem_data_d;
         dmem_we_q   <= dmem_we_d;
         dmem_addr_q <= dmem_addr_d;
         dmem_data_q <= dmem_data_d;
         overflow_q  <= overflow_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         cksum_err_q <= cksum_err_d;
`endif
      end
   end

   // Next state, write routing, counters and sticky flags
   always_comb begin
      state_d     = state_q;
      icnt_d      = icnt_q;
      dcnt_d      = dcnt_q;
      accum_d     = accum_q;
      imem_we_d   = 1'b0;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;
      dmem_we_d   = 1'b0;
      dmem_addr_d = dmem_addr_q;
      dmem_data_d = dmem_data_q;
      overflow_d  = overflow_q;
      payload     = 1'b1;
      xfer        = loadValid && ready_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      cksum_err_d = cksum_err_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = LOAD;
               icnt_d     = '0;
               dcnt_d     = '0;
               accum_d    = '0;
               overflow_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               cksum_err_d = 1'b0;
`endif
            end
         end
         LOAD: begin
            if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               // The closing word carries the expected sum rather than data
               if (loadLast) begin
                  payload     = 1'b0;
                  cksum_err_d = cksum_err_q | (loadWord != accum_q);
               end
`endif
               if (payload) begin
                  accum_d = accum_q + loadWord;
                  if (!loadTarget) begin
                     if (icnt_q == IMEM_FULL) begin
                        overflow_d = 1'b1;
                     end else begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = icnt_q[INSTR_ADDR_WIDTH-1:0];
                        imem_data_d = loadWord;
                        icnt_d      = icnt_q + ICNT_W'(1);
                     end
                  end else begin
                     if (dcnt_q == DMEM_FULL) begin
                        overflow_d = 1'b1;
                     end else begin
                        dmem_we_d   = 1'b1;
                        dmem_addr_d = dcnt_q[DATA_ADDR_WIDTH-1:0];
                        dmem_data_d = loadWord;
                        dcnt_d      = dcnt_q + DCNT_W'(1);
                     end
                  end
               end
               if (loadLast) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == LOAD);
      hold_d  = (state_d != DONE);
      done_d  = (state_d == DONE);
   end

   assign loadReady = ready_q;
   assign coreHold  = hold_q;
   assign done      = done_q;
   assign imemWe    = imem_we_q;
   assign imemAddr  = imem_addr_q;
   assign imemData  = imem_data_q;
   assign dmemWe    = dmem_we_q;
   assign dmemAddr  = dmem_addr_q;
   assign dmemData  = dmem_data_q;
   assign overflow  = overflow_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   assign checksumErr = cksum_err_q;
`else
   assign checksumErr = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-size instance and a 4-deep instruction memory instance.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam logic CK = 1'b1;
`else
   localparam logic CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, loadValid, loadTarget, loadLast;
   logic [31:0] loadWord;

   logic        loadReady, imemWe, dmemWe, coreHold, done, overflow, checksumErr;
   logic [6:0]  imemAddr, dmemAddr;
   logic [31:0] imemData, dmemData;

   logic        s_loadReady, s_imemWe, s_dmemWe, s_coreHold, s_done, s_overflow, s_checksumErr;
   logic [1:0]  s_imemAddr;
   logic [6:0]  s_dmemAddr;
   logic [31:0] s_imemData, s_dmemData;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   program_loader dut (
      .clk(clk), .reset(reset), .start(start), .loadValid(loadValid), .loadReady(loadReady),
      .loadWord(loadWord), .loadTarget(loadTarget), .loadLast(loadLast),
      .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
      .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemData(dmemData),
      .coreHold(coreHold), .done(done), .overflow(overflow), .checksumErr(checksumErr)
   );

   program_loader #(.DATA_WIDTH(32), .INSTR_ADDR_WIDTH(2), .DATA_ADDR_WIDTH(7)) dut_small (
      .clk(clk), .reset(reset), .start(start), .loadValid(loadValid), .loadReady(s_loadReady),
      .loadWord(loadWord), .loadTarget(loadTarget), .loadLast(loadLast),
      .imemWe(s_imemWe), .imemAddr(s_imemAddr), .imemData(s_imemData),
      .dmemWe(s_dmemWe), .dmemAddr(s_dmemAddr), .dmemData(s_dmemData),
      .coreHold(s_coreHold), .done(s_done), .overflow(s_overflow), .checksumErr(s_checksumErr)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One handshake on the default instance; wr says whether a strobe is expected
   task automatic xfer(input logic tgt, input logic [31:0] w, input logic last,
                       input int addr, input logic wr);
      @(negedge clk);
      start = 1'b0; loadValid = 1'b1; loadTarget = tgt; loadWord = w; loadLast = last;
      @(posedge clk); #1;
      check1("imem_we", imemWe, wr & ~tgt);
      check1("dmem_we", dmemWe, wr & tgt);
      if (wr && !tgt) begin
         checkv("imem_addr", 32'(imemAddr), 32'(addr));
         checkv("imem_data", imemData, w);
      end
      if (wr && tgt) begin
         checkv("dmem_addr", 32'(dmemAddr), 32'(addr));
         checkv("dmem_data", dmemData, w);
      end
   endtask

   task automatic drive(input logic tgt, input logic [31:0] w, input logic last);
      @(negedge clk);
      start = 1'b0; loadValid = 1'b1; loadTarget = tgt; loadWord = w; loadLast = last;
      @(posedge clk); #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      start = 1'b0; loadValid = 1'b0;
      @(posedge clk); #1;
      check1("idle_imem_we", imemWe, 1'b0);
      check1("idle_dmem_we", dmemWe, 1'b0);
   endtask

   task automatic start_session();
      @(negedge clk);
      start = 1'b1; loadValid = 1'b0;
      @(posedge clk); #1;
      check1("start_ready", loadReady, 1'b1);
      check1("start_hold", coreHold, 1'b1);
      check1("start_done", done, 1'b0);
      check1("start_overflow", overflow, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1; start = 1'b0; loadValid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check1("rst_hold", coreHold, 1'b1);
      check1("rst_done", done, 1'b0);
      check1("rst_ready", loadReady, 1'b0);
      check1("rst_imem_we", imemWe, 1'b0);
      check1("rst_dmem_we", dmemWe, 1'b0);
      check1("rst_overflow", overflow, 1'b0);
      check1("rst_ckerr", checksumErr, 1'b0);
      checkv("rst_imem_addr", 32'(imemAddr), 32'd0);
      checkv("rst_dmem_addr", 32'(dmemAddr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic end_checks(input logic exp_ckerr);
      check1("end_done", done, 1'b1);
      check1("end_hold", coreHold, 1'b0);
      check1("end_ready", loadReady, 1'b0);
      check1("end_ckerr", checksumErr, exp_ckerr);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; loadValid = 1'b0; loadTarget = 1'b0;
      loadLast = 1'b0; loadWord = 32'd0;

      do_reset(2);
      idle_cycle();
      check1("idle_ready", loadReady, 1'b0);

      // Basic session: three instruction words, two data words
      start_session();
      xfer(1'b0, 32'h20010003, 1'b0, 0, 1'b1);
      xfer(1'b0, 32'h8C010000, 1'b0, 1, 1'b1);
      xfer(1'b0, 32'hAC010000, 1'b0, 2, 1'b1);
      xfer(1'b1, 32'd12,       1'b0, 0, 1'b1);
      xfer(1'b1, 32'd34,       1'b1, 1, ~CK);
      end_checks(CK);
      idle_cycle();
      check1("done_stays", done, 1'b1);

      // Restart from DONE with valid toggled every other cycle
      start_session();
      xfer(1'b0, 32'h20010003, 1'b0, 0, 1'b1);
      idle_cycle();
      xfer(1'b0, 32'h8C010000, 1'b0, 1, 1'b1);
      idle_cycle();
      xfer(1'b0, 32'hAC010000, 1'b0, 2, 1'b1);
      idle_cycle();
      xfer(1'b1, 32'd12,       1'b0, 0, 1'b1);
      idle_cycle();
      check1("gap_done", done, 1'b0);
      xfer(1'b1, 32'd34,       1'b1, 1, ~CK);
      end_checks(CK);
      idle_cycle();

      // Four-deep instruction memory: fifth word is dropped
      start_session();
      check1("s_start_overflow", s_overflow, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h100 + 32'(i), 1'b0);
         check1("s_imem_we", s_imemWe, 1'b1);
         checkv("s_imem_addr", 32'(s_imemAddr), 32'(i));
         checkv("s_imem_data", s_imemData, 32'h100 + 32'(i));
         check1("s_no_ovf_yet", s_overflow, 1'b0);
      end
      drive(1'b0, 32'h104, 1'b0);
      check1("s_drop_we", s_imemWe, 1'b0);
      check1("s_overflow_set", s_overflow, 1'b1);
      check1("big_no_overflow", overflow, 1'b0);
      drive(1'b1, 32'h55, 1'b1);
      check1("s_last_dmem_we", s_dmemWe, ~CK);
      check1("s_done", s_done, 1'b1);
      check1("s_overflow_done", s_overflow, 1'b1);
      idle_cycle();
      check1("s_overflow_sticky", s_overflow, 1'b1);
      check1("s_done_stays", s_done, 1'b1);

      // Checksum matching session (data 1,2,3 then 6)
      start_session();
      xfer(1'b1, 32'd1, 1'b0, 0, 1'b1);
      xfer(1'b1, 32'd2, 1'b0, 1, 1'b1);
      xfer(1'b1, 32'd3, 1'b0, 2, 1'b1);
      xfer(1'b1, 32'd6, 1'b1, 3, ~CK);
      end_checks(1'b0);
      idle_cycle();

      // Checksum mismatching session (data 1,2,3 then 7)
      start_session();
      check1("ckerr_cleared", checksumErr, 1'b0);
      xfer(1'b1, 32'd1, 1'b0, 0, 1'b1);
      xfer(1'b1, 32'd2, 1'b0, 1, 1'b1);
      xfer(1'b1, 32'd3, 1'b0, 2, 1'b1);
      xfer(1'b1, 32'd7, 1'b1, 3, ~CK);
      end_checks(CK);
      idle_cycle();

      // Reset in the middle of a session, then a fresh session from address 0
      start_session();
      xfer(1'b0, 32'hA, 1'b0, 0, 1'b1);
      xfer(1'b0, 32'hB, 1'b0, 1, 1'b1);
      do_reset(1);
      idle_cycle();
      start_session();
      xfer(1'b0, 32'hC, 1'b0, 0, 1'b1);
      xfer(1'b1, 32'hD, 1'b1, 0, ~CK);
      check1("final_done", done, 1'b1);
      check1("final_hold", coreHold, 1'b0);
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
